// File: rtl/mem_arbiter.sv
// Round-robin scheduler of per-port read/write beats onto one shared memory port (optional ARB_WR_PRIORITY_EN: writes first).
// Latency: request sampled at edge t -> grant in cycle t+1; o_rd_valid one cycle after o_grant_rd; zero-bubble hand-off.
// Backpressure: a port's request level is its demand; it holds the request until granted, bursts are capped at MAX_BURST.
module mem_arbiter #(
    parameter int PORT_COUNT = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic [PORT_COUNT-1:0]         i_req_rd,
    input  logic [PORT_COUNT-1:0]         i_req_wr,
    output logic [PORT_COUNT-1:0]         o_grant_rd,
    output logic [PORT_COUNT-1:0]         o_grant_wr,
    output logic [PORT_COUNT-1:0]         o_rd_valid,
    output logic [$clog2(PORT_COUNT)-1:0] o_owner,
    output logic                          o_owner_wr,
    output logic                          o_busy
);

    localparam int PW = $clog2(PORT_COUNT);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {ST_IDLE, ST_OWN} state_t;

    state_t              state;
    logic [PW-1:0]       ptr;
    logic [CW-1:0]       cnt;

    logic                sel_vld;
    logic [PW-1:0]       sel_port;
    logic                sel_wr;
    logic [PORT_COUNT-1:0] sel_onehot;
    logic [PW-1:0]       ptr_next;
    logic                own_req;
    logic                cont;

    // Offsets are scanned from farthest to nearest so the port closest to ptr wins.
    always_comb begin
        int idx;
        idx      = 0;
        sel_vld  = 1'b0;
        sel_port = '0;
        sel_wr   = 1'b0;
`ifdef ARB_WR_PRIORITY_EN
        for (int k = PORT_COUNT - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= PORT_COUNT) idx = idx - PORT_COUNT;
            if (i_req_rd[idx]) begin
                sel_vld  = 1'b1;
                sel_port = PW'(idx);
                sel_wr   = 1'b0;
            end
        end
        // Second pass lets any pending write override every read.
        for (int k = PORT_COUNT - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= PORT_COUNT) idx = idx - PORT_COUNT;
            if (i_req_wr[idx]) begin
                sel_vld  = 1'b1;
                sel_port = PW'(idx);
                sel_wr   = 1'b1;
            end
        end
`else
        for (int k = PORT_COUNT - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= PORT_COUNT) idx = idx - PORT_COUNT;
            if (i_req_rd[idx]) begin
                sel_vld  = 1'b1;
                sel_port = PW'(idx);
                sel_wr   = 1'b0;
            end else if (i_req_wr[idx]) begin
                sel_vld  = 1'b1;
                sel_port = PW'(idx);
                sel_wr   = 1'b1;
            end
        end
`endif
    end

    assign sel_onehot = {{(PORT_COUNT-1){1'b0}}, 1'b1} << sel_port;
    assign ptr_next   = (sel_port == PW'(PORT_COUNT - 1)) ? '0 : sel_port + PW'(1);
    assign own_req    = o_owner_wr ? i_req_wr[o_owner] : i_req_rd[o_owner];
    assign cont       = own_req && (cnt < CW'(MAX_BURST));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            cnt        <= '0;
            o_grant_rd <= '0;
            o_grant_wr <= '0;
            o_rd_valid <= '0;
            o_owner    <= '0;
            o_owner_wr <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_rd_valid <= o_grant_rd;
            if (state == ST_OWN && cont) begin
                cnt <= cnt + CW'(1);
            end else if (sel_vld) begin
                state      <= ST_OWN;
                ptr        <= ptr_next;
                cnt        <= CW'(1);
                o_grant_rd <= sel_wr ? '0 : sel_onehot;
                o_grant_wr <= sel_wr ? sel_onehot : '0;
                o_owner    <= sel_port;
                o_owner_wr <= sel_wr;
                o_busy     <= 1'b1;
            end else begin
                // Owner and owner_wr keep their last value while idle.
                state      <= ST_IDLE;
                cnt        <= '0;
                o_grant_rd <= '0;
                o_grant_wr <= '0;
                o_busy     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected beats (absolute cycle stamped); a negedge monitor checks them.
module tb_mem_arbiter;

    logic       clk;
    logic       rstn;
    logic [3:0] req_rd;
    logic [3:0] req_wr;
    logic [3:0] grant_rd;
    logic [3:0] grant_wr;
    logic [3:0] rd_valid;
    logic [1:0] owner;
    logic       owner_wr;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         c;
        logic [3:0] grd;
        logic [3:0] gwr;
        logic [1:0] own;
        logic       ownwr;
    } exp_t;

    exp_t exp_q[$];
    logic [3:0] prev_grd = '0;

    mem_arbiter #(.PORT_COUNT(4), .MAX_BURST(4)) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_req_rd   (req_rd),
        .i_req_wr   (req_wr),
        .o_grant_rd (grant_rd),
        .o_grant_wr (grant_wr),
        .o_rd_valid (rd_valid),
        .o_owner    (owner),
        .o_owner_wr (owner_wr),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
        end
    endtask

    task automatic push(input int c, input logic [3:0] grd, input logic [3:0] gwr,
                        input logic [1:0] own, input logic ownwr);
        exp_t e;
        e.c = c; e.grd = grd; e.gwr = gwr; e.own = own; e.ownwr = ownwr;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        chk("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        rstn   = 1'b0;
        req_rd = '0;
        req_wr = '0;
        repeat (3) step();
        rstn = 1'b1;
        step();
    endtask

    // Monitor: every cycle compares outputs with the expected beat (or with "no grant").
    always @(negedge clk) begin
        exp_t e;
        e.c = cyc; e.grd = '0; e.gwr = '0; e.own = '0; e.ownwr = 1'b0;
        if (!rstn) begin
            chk("rst_grant_rd", grant_rd, 4'h0);
            chk("rst_grant_wr", grant_wr, 4'h0);
            chk("rst_rd_valid", rd_valid, 4'h0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_owner", owner, 2'd0);
            chk("rst_owner_wr", owner_wr, 1'b0);
            prev_grd = '0;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
                total++;
                bad++;
                $display("FAIL beat_missing due_cyc=%0d now=%0d", exp_q[0].c, cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
                e = exp_q.pop_front();
                chk("owner", owner, e.own);
                chk("owner_wr", owner_wr, e.ownwr);
            end
            chk("grant_rd", grant_rd, e.grd);
            chk("grant_wr", grant_wr, e.gwr);
            chk("busy", busy, (e.grd | e.gwr) != 4'h0);
            chk("rd_valid", rd_valid, prev_grd);
            prev_grd = e.grd;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int b;
        int r;
        logic [3:0] oh;
        rstn   = 1'b0;
        req_rd = '0;
        req_wr = '0;
        repeat (3) step();
        rstn = 1'b1;
        repeat (2) step();

        // Single read from port 2, then idle with owner held.
        b = cyc;
        req_rd = 4'b0100;
        push(b + 1, 4'b0100, 4'b0000, 2'd2, 1'b0);
        step();
        req_rd = '0;
        repeat (4) step();
        drain();
        chk("owner_hold", owner, 2'd2);

        // Burst cap: port 0 writes 10 cycles, port 1 reads.
        b = cyc;
        req_wr = 4'b0001;
        req_rd = 4'b0010;
        for (int i = 1; i <= 4; i++) push(b + i, 4'b0000, 4'b0001, 2'd0, 1'b1);
        for (int i = 5; i <= 8; i++) push(b + i, 4'b0010, 4'b0000, 2'd1, 1'b0);
        for (int i = 9; i <= 10; i++) push(b + i, 4'b0000, 4'b0001, 2'd0, 1'b1);
        repeat (8) step();
        req_rd = '0;
        repeat (2) step();
        req_wr = '0;
        repeat (4) step();
        drain();

        // Full contention from reset: 0,1,2,3,0 with 4 beats each.
        do_reset();
        b = cyc;
        req_rd = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            for (int i = 1; i <= 4; i++) push(b + 4 * k + i, oh, 4'b0000, 2'(k % 4), 1'b0);
        end
        repeat (20) step();
        req_rd = '0;
        repeat (4) step();
        drain();

        // Same-port rd+wr on port 3, two beats each.
        b = cyc;
        req_rd = 4'b1000;
        req_wr = 4'b1000;
`ifdef ARB_WR_PRIORITY_EN
        push(b + 1, 4'b0000, 4'b1000, 2'd3, 1'b1);
        push(b + 2, 4'b0000, 4'b1000, 2'd3, 1'b1);
        push(b + 3, 4'b1000, 4'b0000, 2'd3, 1'b0);
        push(b + 4, 4'b1000, 4'b0000, 2'd3, 1'b0);
        repeat (2) step();
        req_wr = '0;
        repeat (2) step();
        req_rd = '0;
`else
        push(b + 1, 4'b1000, 4'b0000, 2'd3, 1'b0);
        push(b + 2, 4'b1000, 4'b0000, 2'd3, 1'b0);
        push(b + 3, 4'b0000, 4'b1000, 2'd3, 1'b1);
        push(b + 4, 4'b0000, 4'b1000, 2'd3, 1'b1);
        repeat (2) step();
        req_rd = '0;
        repeat (2) step();
        req_wr = '0;
`endif
        repeat (4) step();
        drain();

        // Async reset during port 1's second beat; restart searches from port 0.
        b = cyc;
        req_rd = 4'b0010;
        push(b + 1, 4'b0010, 4'b0000, 2'd1, 1'b0);
        repeat (2) step();
        #2;
        rstn   = 1'b0;
        req_rd = 4'b1001;
        repeat (2) step();
        rstn = 1'b1;
        r = cyc;
        push(r + 1, 4'b0001, 4'b0000, 2'd0, 1'b0);
        push(r + 2, 4'b1000, 4'b0000, 2'd3, 1'b0);
        step();
        req_rd = 4'b1000;
        step();
        req_rd = '0;
        repeat (4) step();
        drain();

        // Early drop: port 1 leaves after one beat, port 2 takes over with no bubble.
        b = cyc;
        req_rd = 4'b0110;
        push(b + 1, 4'b0010, 4'b0000, 2'd1, 1'b0);
        push(b + 2, 4'b0100, 4'b0000, 2'd2, 1'b0);
        step();
        req_rd = 4'b0100;
        step();
        req_rd = '0;
        repeat (3) step();
        drain();
        chk("idle_owner", owner, 2'd2);
        chk("idle_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin access scheduler placed between the processor pool's per-port read/write requests and the single shared-memory access port. It grants at most one port per cycle, lets the owning port stream up to `MAX_BURST` back-to-back beats, then rotates priority so every port has a bounded wait. It also produces the read-data-valid strobes that return memory data to the pool.

## Interface
- `PORT_COUNT`, default 4: number of requesting processor ports. Must be ≥ 2.
- `MAX_BURST`, default 4: maximum consecutive beats per ownership. Must be ≥ 1.
- `i_clk`, input, 1: clock.
- `i_rstn`, input, 1: asynchronous, active-low reset.
- `i_req_rd`, input, PORT_COUNT: per-port read request. A high level means one beat is wanted.
- `i_req_wr`, input, PORT_COUNT: per-port write request. A high level means one beat is wanted.
- `o_grant_rd`, output, PORT_COUNT: registered, one-hot or zero. The read beat is accepted in this cycle.
- `o_grant_wr`, output, PORT_COUNT: registered, one-hot or zero. The write beat is accepted in this cycle.
- `o_rd_valid`, output, PORT_COUNT: `o_grant_rd` delayed one cycle. Memory read data is valid in this cycle.
- `o_owner`, output, $clog2(PORT_COUNT): index of the current owner. Drives the memory address/data mux.
- `o_owner_wr`, output, 1: the current beat is a write.
- `o_busy`, output, 1: a grant is active in this cycle.

## Operation
- Reset values: all outputs are 0. State = IDLE, rotation pointer `ptr` = 0, beat counter = 0.
- The FSM has two states: IDLE and OWN.
- **IDLE:** sample requests. If any are present, select a winner, then next cycle go to OWN with the grant asserted and beat counter = 1. If none are present, stay in IDLE with no grant.
- **Winner selection:**
  - Search the ports for the first requesting port, starting at `ptr` and wrapping modulo PORT_COUNT.
  - Within a port, read wins over write.
  - On a new winner, `ptr` ← winner + 1 (mod PORT_COUNT).
- **OWN, per cycle:** the granted beat completes. Then:
  - **Continue:** the owner still asserts the same request type and beat counter < MAX_BURST. Keep the same grant next cycle and increment the counter.
  - **Release:** the owner dropped the request, switched type, or the counter reached MAX_BURST.
    - If any other request is pending (including the owner's other type or its renewed request), select the next winner from `ptr` and grant it next cycle with no bubble. Counter = 1.
    - If no request is pending, return to IDLE.
- **Beat accounting:** a request that is high during a granted cycle asks for one more beat.
  - A port with exactly one beat drops its request in the cycle its grant is high.
  - A request still high on the last beat of a burst is re-arbitrated, not lost.
- **Fairness:** the wait from request to grant is at most (PORT_COUNT−1)·MAX_BURST + 1 cycles.
- `o_rd_valid[p]` is 1 exactly one cycle after `o_grant_rd[p]`. It is independent of subsequent grants.
- Simultaneous rd and wr from the same port are served as separate ownerships (read first), unless `ARB_WR_PRIORITY_EN` is defined.

## Timing
- Request to grant from IDLE: request seen at edge t, grant high in cycle t+1.
- Owner hand-off: 0 idle cycles between the last beat of one owner and the first beat of the next.
- Read data return: `o_rd_valid` at grant + 1 cycle, matching the memory's one-cycle read latency.
- Asynchronous reset mid-burst:
  - Grants, valids, `o_busy` and the counter clear immediately.
  - `ptr` returns to 0 and the in-flight beat is discarded.
  - The first grant after release is taken from the requests sampled at the first clock edge after `i_rstn` rises.
- `o_owner` and `o_owner_wr` hold their last value while IDLE. Consumers qualify them with `o_busy`.

## Configuration
- `ARB_WR_PRIORITY_EN` defined:
  - At every selection point, pending writes (round-robin from `ptr`) win over all reads.
  - Reads are considered only when no write is pending.
  - Within a port, write beats read.
  - Burst continuation rules are unchanged.
- Undefined: a single round-robin over ports, with read over write within a port.

## Test plan
- **Single read:** reset, then port 2 holds `i_req_rd` for 1 cycle → `o_grant_rd` = 4'b0100 in the next cycle, `o_rd_valid` = 4'b0100 one cycle later, `o_owner` = 2, then IDLE.
- **Burst cap:** MAX_BURST = 4, port 0 holds `i_req_wr` for 10 cycles while port 1 holds `i_req_rd` → port 0 gets 4 write grants, port 1 gets 4 read grants, then port 0 again. No gap between owners.
- **Full contention:** all 4 ports hold `i_req_rd` continuously from reset → grant order is ports 0,1,2,3,0… with 4 beats each. No port waits more than 13 cycles.
- **Same-port rd+wr:** port 3 asserts both requests for 2 beats each.
  - Without the macro: 2 read grants, then 2 write grants.
  - With `ARB_WR_PRIORITY_EN`: writes first.
- **Async reset mid-burst:** `i_rstn` pulled low during port 1's 2nd beat → all outputs are 0 in the same cycle, with no `o_rd_valid` afterwards. After release with port 3 requesting, port 3 is granted with `ptr` = 0 search order.
- **Early drop:** port 1 requests a 2-beat burst but drops its request after the 1st grant → exactly 1 grant, then an immediate hand-off to pending port 2.
